// File: rtl/axi_pkg.sv
// Shared AXI response definitions for the write response dispatcher.
//   resp_t        : BRESP encoding (OKAY, EXOKAY, SLVERR, DECERR)
//   resp_is_error : true for SLVERR and DECERR (BRESP[1] set)
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_write_response_channel.sv
// AXI write response (B) channel bundle.
//   master modport : consumer of responses (bid/bresp/buser/bvalid in, bready out)
//   slave modport  : producer of responses
interface axi_write_response_channel #(
  parameter int ID_WIDTH   = 2,
  parameter int USER_WIDTH = 0
);
  // A zero-width user field still needs one physical bit to be declarable.
  localparam int UW = (USER_WIDTH > 0) ? USER_WIDTH : 1;

  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic [UW-1:0]       buser;
  logic                bvalid;
  logic                bready;

  modport master (input bid, input bresp, input buser, input bvalid, output bready);
  modport slave  (output bid, output bresp, output buser, output bvalid, input bready);
endinterface

// File: rtl/axi_outstanding_counter.sv
// Saturating up/down counter tracking outstanding writes for one ID.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   inc, dec     : one write issued / one expected response retired
//   count        : current outstanding count
//   full, empty  : count == MAX / count == 0
module axi_outstanding_counter
  import axi_pkg::*;
#(
  parameter int  MAX = 8,
  localparam int CW  = $clog2(MAX + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count; simultaneous inc and dec cancel out.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q != CW'(MAX))) begin
      count_d = count_q + CW'(1);
    end else if (dec && !inc && (count_q != CW'(0))) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= CW'(0);
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == CW'(MAX));
  assign empty = (count_q == CW'(0));

endmodule

// File: rtl/axi_write_response_dispatcher.sv
// Routes B-channel responses to NUM_PORTS requesters by BID, tracks
// outstanding writes per ID, drops unexpected responses and captures the
// first error response.
//   clock, reset            : rising-edge clock, async active-high reset
//   b                       : shared B channel (master side)
//   issue_valid/id/ready    : write issue throttle (ready is combinational)
//   done_valid/resp/ready   : per-requester completion handshake
//   idle                    : nothing outstanding, holding register empty
//   err_valid/id/resp       : sticky first SLVERR/DECERR
//   unexp_valid             : sticky unexpected-response flag
//   err_clear               : clears err_valid and unexp_valid
module axi_write_response_dispatcher
  import axi_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int AXI_BID_WIDTH   = 2,
  parameter int AXI_BUSER_WIDTH = 0,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  axi_write_response_channel.master  b,
  input  logic                       issue_valid,
  input  logic [AXI_BID_WIDTH-1:0]   issue_id,
  output logic                       issue_ready,
  output logic [NUM_PORTS-1:0]       done_valid,
  output logic [NUM_PORTS*2-1:0]     done_resp,
  input  logic [NUM_PORTS-1:0]       done_ready,
  output logic                       idle,
  output logic                       err_valid,
  output logic [AXI_BID_WIDTH-1:0]   err_id,
  output logic [1:0]                 err_resp,
  output logic                       unexp_valid,
  input  logic                       err_clear
);

  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  // Per-ID tables cover the full BID space so any bid/issue_id indexes safely.
  localparam int NID = 1 << AXI_BID_WIDTH;

  logic [NID-1:0] port_ok_s;
  logic [NID-1:0] full_s;
  logic [NID-1:0] empty_s;
  logic [NID-1:0] inc_s;
  logic [NID-1:0] dec_s;
  logic [NID-1:0] done_ready_ext_s;
  logic [CW-1:0]  cnt_s [NID];

  logic issue_fire_s;
  logic b_accept_s;
  logic b_exp_s;
  logic b_unexp_s;
  logic unused_buser_s;

  logic                     hold_valid_q, hold_valid_d;
  logic [AXI_BID_WIDTH-1:0] hold_id_q,    hold_id_d;
  resp_t                    hold_resp_q,  hold_resp_d;
  logic                     err_valid_q,  err_valid_d;
  logic [AXI_BID_WIDTH-1:0] err_id_q,     err_id_d;
  resp_t                    err_resp_q,   err_resp_d;
  logic                     unexp_valid_q, unexp_valid_d;

  genvar gi;
  generate
    for (gi = 0; gi < NID; gi++) begin : g_id
      if (gi < NUM_PORTS) begin : g_port
        assign port_ok_s[gi]        = 1'b1;
        assign done_ready_ext_s[gi] = done_ready[gi];
        assign inc_s[gi] = issue_fire_s && (issue_id == AXI_BID_WIDTH'(gi));
        assign dec_s[gi] = b_exp_s && (b.bid == AXI_BID_WIDTH'(gi));
        axi_outstanding_counter #(.MAX(MAX_OUTSTANDING)) u_cnt (
          .clock (clock),
          .reset (reset),
          .inc   (inc_s[gi]),
          .dec   (dec_s[gi]),
          .count (cnt_s[gi]),
          .full  (full_s[gi]),
          .empty (empty_s[gi])
        );
      end else begin : g_pad
        // IDs with no requester: never issuable, never expected, count as idle.
        assign port_ok_s[gi]        = 1'b0;
        assign done_ready_ext_s[gi] = 1'b0;
        assign inc_s[gi]            = 1'b0;
        assign dec_s[gi]            = 1'b0;
        assign cnt_s[gi]            = CW'(0);
        assign full_s[gi]           = 1'b1;
        assign empty_s[gi]          = 1'b1;
      end
    end
  endgenerate

  assign issue_ready  = port_ok_s[issue_id] && !full_s[issue_id];
  assign issue_fire_s = issue_valid && issue_ready;

  // The holding register frees in the same cycle its owner accepts it.
  assign b.bready   = !hold_valid_q || done_ready_ext_s[hold_id_q];
  assign b_accept_s = b.bvalid && b.bready;
  assign b_exp_s    = b_accept_s && port_ok_s[b.bid] && (cnt_s[b.bid] != CW'(0));
  assign b_unexp_s  = b_accept_s && !b_exp_s;

  assign unused_buser_s = ^b.buser;

  // Holding register next state: load expected beats, drain on done handshake.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_id_d    = hold_id_q;
    hold_resp_d  = hold_resp_q;
    if (b_exp_s) begin
      hold_valid_d = 1'b1;
      hold_id_d    = b.bid;
      hold_resp_d  = resp_t'(b.bresp);
    end else if (hold_valid_q && done_ready_ext_s[hold_id_q]) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // Sticky status next state; a new event in the clearing cycle wins.
  always_comb begin
    err_valid_d   = err_valid_q;
    err_id_d      = err_id_q;
    err_resp_d    = err_resp_q;
    unexp_valid_d = unexp_valid_q;
    if (err_clear) begin
      err_valid_d   = 1'b0;
      unexp_valid_d = 1'b0;
    end else begin
      err_valid_d   = err_valid_q;
      unexp_valid_d = unexp_valid_q;
    end
    if (b_exp_s && resp_is_error(b.bresp) && (!err_valid_q || err_clear)) begin
      err_valid_d = 1'b1;
      err_id_d    = b.bid;
      err_resp_d  = resp_t'(b.bresp);
    end else begin
      err_id_d    = err_id_q;
      err_resp_d  = err_resp_q;
    end
    if (b_unexp_s) begin
      unexp_valid_d = 1'b1;
    end else begin
      unexp_valid_d = unexp_valid_d;
    end
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid_q  <= 1'b0;
      hold_id_q     <= AXI_BID_WIDTH'(0);
      hold_resp_q   <= OKAY;
      err_valid_q   <= 1'b0;
      err_id_q      <= AXI_BID_WIDTH'(0);
      err_resp_q    <= OKAY;
      unexp_valid_q <= 1'b0;
    end else begin
      hold_valid_q  <= hold_valid_d;
      hold_id_q     <= hold_id_d;
      hold_resp_q   <= hold_resp_d;
      err_valid_q   <= err_valid_d;
      err_id_q      <= err_id_d;
      err_resp_q    <= err_resp_d;
      unexp_valid_q <= unexp_valid_d;
    end
  end

  // Completion outputs decode straight from the holding register.
  always_comb begin
    done_valid = '0;
    done_resp  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      done_valid[i]      = hold_valid_q && (hold_id_q == AXI_BID_WIDTH'(i));
      done_resp[2*i +: 2] = hold_resp_q;
    end
  end

  assign idle        = (&empty_s) && !hold_valid_q;
  assign err_valid   = err_valid_q;
  assign err_id      = err_id_q;
  assign err_resp    = err_resp_q;
  assign unexp_valid = unexp_valid_q;

endmodule

// File: tb/tb_axi_write_response_dispatcher.sv
module tb_axi_write_response_dispatcher;

  logic       clock;
  logic       reset;
  logic       issue_valid;
  logic [1:0] issue_id;
  logic       issue_ready;
  logic [3:0] done_valid;
  logic [7:0] done_resp;
  logic [3:0] done_ready;
  logic       idle;
  logic       err_valid;
  logic [1:0] err_id;
  logic [1:0] err_resp;
  logic       unexp_valid;
  logic       err_clear;

  // Second instance with only three requesters.
  logic       issue_valid3;
  logic [1:0] issue_id3;
  logic       issue_ready3;
  logic [2:0] done_valid3;
  logic [5:0] done_resp3;
  logic [2:0] done_ready3;
  logic       idle3;
  logic       err_valid3;
  logic [1:0] err_id3;
  logic [1:0] err_resp3;
  logic       unexp_valid3;
  logic       err_clear3;

  int checks;
  int errors;
  int cnt_m [4];
  logic [3:0] sb_q [$];

  axi_write_response_channel #(.ID_WIDTH(2), .USER_WIDTH(0)) b_if ();
  axi_write_response_channel #(.ID_WIDTH(2), .USER_WIDTH(0)) b3_if ();

  axi_write_response_dispatcher #(
    .NUM_PORTS(4), .AXI_BID_WIDTH(2), .AXI_BUSER_WIDTH(0), .MAX_OUTSTANDING(8)
  ) dut (
    .clock(clock), .reset(reset), .b(b_if),
    .issue_valid(issue_valid), .issue_id(issue_id), .issue_ready(issue_ready),
    .done_valid(done_valid), .done_resp(done_resp), .done_ready(done_ready),
    .idle(idle), .err_valid(err_valid), .err_id(err_id), .err_resp(err_resp),
    .unexp_valid(unexp_valid), .err_clear(err_clear)
  );

  axi_write_response_dispatcher #(
    .NUM_PORTS(3), .AXI_BID_WIDTH(2), .AXI_BUSER_WIDTH(0), .MAX_OUTSTANDING(8)
  ) dut3 (
    .clock(clock), .reset(reset), .b(b3_if),
    .issue_valid(issue_valid3), .issue_id(issue_id3), .issue_ready(issue_ready3),
    .done_valid(done_valid3), .done_resp(done_resp3), .done_ready(done_ready3),
    .idle(idle3), .err_valid(err_valid3), .err_id(err_id3), .err_resp(err_resp3),
    .unexp_valid(unexp_valid3), .err_clear(err_clear3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard monitor: a completion handshake completes at the next rising
  // edge when valid and ready are both high mid-cycle.
  always @(negedge clock) begin
    logic [3:0] e;
    logic [3:0] got;
    if (!reset) begin
      if (done_valid != 4'b0000) begin
        checks++;
        if ($countones(done_valid) != 1) begin
          errors++;
          $display("FAIL done_onehot got=%b required exactly one bit", done_valid);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (done_valid[i] && done_ready[i]) begin
          checks++;
          got = {2'(i), done_resp[2*i +: 2]};
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra port=%0d resp=%0d required no completion", i, got[1:0]);
          end else begin
            e = sb_q.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL sb_order got id=%0d resp=%0d required id=%0d resp=%0d",
                       got[3:2], got[1:0], e[3:2], e[1:0]);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    issue_valid = 1'b0; issue_id = 2'd0; done_ready = 4'hF; err_clear = 1'b0;
    b_if.bvalid = 1'b0; b_if.bid = 2'd0; b_if.bresp = 2'd0; b_if.buser = 1'b0;
    issue_valid3 = 1'b0; issue_id3 = 2'd0; done_ready3 = 3'h7; err_clear3 = 1'b0;
    b3_if.bvalid = 1'b0; b3_if.bid = 2'd0; b3_if.bresp = 2'd0; b3_if.buser = 1'b0;
    for (int i = 0; i < 4; i++) cnt_m[i] = 0;
    sb_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic do_issue(input logic [1:0] id);
    logic exp_rdy;
    exp_rdy = (cnt_m[id] < 8);
    issue_valid = 1'b1;
    issue_id = id;
    #1;
    checks++;
    if (issue_ready !== exp_rdy) begin
      errors++;
      $display("FAIL issue_ready id=%0d got=%b required=%b", id, issue_ready, exp_rdy);
    end
    @(posedge clock);
    #1;
    if (exp_rdy) cnt_m[id]++;
    issue_valid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] id, input logic [1:0] resp);
    bit acc;
    acc = 1'b0;
    b_if.bvalid = 1'b1;
    b_if.bid = id;
    b_if.bresp = resp;
    for (int k = 0; k < 20 && !acc; k++) begin
      #1;
      if (b_if.bready === 1'b1) acc = 1'b1;
      @(posedge clock);
      #1;
    end
    b_if.bvalid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL b_accept_timeout id=%0d got bready=0 required bready=1", id);
    end else if (cnt_m[id] > 0) begin
      cnt_m[id]--;
      sb_q.push_back({id, resp});
    end
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({idle, b_if.bready, done_valid, err_valid, unexp_valid, err_id, err_resp} !== 12'b11_0000_00_00_00) begin
      errors++;
      $display("FAIL reset_state got idle=%b bready=%b dv=%b ev=%b uv=%b eid=%0d eresp=%0d required 1 1 0000 0 0 0 0",
               idle, b_if.bready, done_valid, err_valid, unexp_valid, err_id, err_resp);
    end
    for (int n = 0; n < 3; n++) do_issue(2'd1);
    checks++;
    if (idle !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_issue got idle=%b required 0", idle);
    end
    for (int n = 0; n < 3; n++) send_b(2'd1, 2'd0);
    step(); step();
    checks++;
    if (idle !== 1'b1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL reset_flow_drain got idle=%b pending=%0d required idle=1 pending=0", idle, sb_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    do_issue(2'd1); do_issue(2'd1);
    done_ready = 4'b1101;
    send_b(2'd1, 2'd0);
    reset = 1'b1;
    #1;
    checks++;
    if (done_valid !== 4'b0000 || idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_discard got dv=%b idle=%b required 0000 1", done_valid, idle);
    end
    apply_reset();
    send_b(2'd1, 2'd0);
    checks++;
    if (unexp_valid !== 1'b1 || done_valid !== 4'b0000 || idle !== 1'b1) begin
      errors++;
      $display("FAIL stale_resp got uv=%b dv=%b idle=%b required 1 0000 1", unexp_valid, done_valid, idle);
    end
    pulse_clear();
  endtask

  task automatic test_throttle();
    done_ready = 4'hF;
    for (int n = 0; n < 8; n++) do_issue(2'd2);
    do_issue(2'd2);
    issue_id = 2'd0;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL throttle_other_id got=%b required 1", issue_ready);
    end
    send_b(2'd2, 2'd0);
    issue_id = 2'd2;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL throttle_release got=%b required 1", issue_ready);
    end
    do_issue(2'd2);
    for (int n = 0; n < 8; n++) send_b(2'd2, 2'd0);
    step(); step();
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL throttle_drain got idle=%b required 1", idle);
    end
  endtask

  task automatic test_backpressure();
    done_ready = 4'b1110;
    do_issue(2'd0); do_issue(2'd0);
    send_b(2'd0, 2'd0);
    checks++;
    if (b_if.bready !== 1'b0 || done_valid !== 4'b0001) begin
      errors++;
      $display("FAIL bp_hold got bready=%b dv=%b required 0 0001", b_if.bready, done_valid);
    end
    b_if.bvalid = 1'b1; b_if.bid = 2'd0; b_if.bresp = 2'd1;
    for (int n = 0; n < 2; n++) begin
      step();
      checks++;
      if (b_if.bready !== 1'b0 || done_valid !== 4'b0001) begin
        errors++;
        $display("FAIL bp_stall got bready=%b dv=%b required 0 0001", b_if.bready, done_valid);
      end
    end
    done_ready = 4'hF;
    #1;
    checks++;
    if (b_if.bready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got bready=%b required 1", b_if.bready);
    end
    @(posedge clock);
    #1;
    b_if.bvalid = 1'b0;
    cnt_m[0]--;
    sb_q.push_back({2'd0, 2'd1});
    step(); step();
    checks++;
    if (sb_q.size() != 0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain got pending=%0d idle=%b required 0 1", sb_q.size(), idle);
    end
  endtask

  task automatic test_unexpected();
    send_b(2'd3, 2'd0);
    checks++;
    if (unexp_valid !== 1'b1 || done_valid !== 4'b0000 || idle !== 1'b1) begin
      errors++;
      $display("FAIL unexp_drop got uv=%b dv=%b idle=%b required 1 0000 1", unexp_valid, done_valid, idle);
    end
    err_clear = 1'b1;
    send_b(2'd3, 2'd0);
    err_clear = 1'b0;
    checks++;
    if (unexp_valid !== 1'b1) begin
      errors++;
      $display("FAIL unexp_clear_race got uv=%b required 1", unexp_valid);
    end
    pulse_clear();
    checks++;
    if (unexp_valid !== 1'b0) begin
      errors++;
      $display("FAIL unexp_clear got uv=%b required 0", unexp_valid);
    end
    issue_id3 = 2'd3;
    b3_if.bvalid = 1'b1; b3_if.bid = 2'd3; b3_if.bresp = 2'd0;
    #1;
    checks++;
    if (issue_ready3 !== 1'b0 || b3_if.bready !== 1'b1) begin
      errors++;
      $display("FAIL np3_ready got issue_ready=%b bready=%b required 0 1", issue_ready3, b3_if.bready);
    end
    step();
    b3_if.bvalid = 1'b0;
    checks++;
    if (unexp_valid3 !== 1'b1 || done_valid3 !== 3'b000 || idle3 !== 1'b1) begin
      errors++;
      $display("FAIL np3_drop got uv=%b dv=%b idle=%b required 1 000 1", unexp_valid3, done_valid3, idle3);
    end
  endtask

  task automatic test_errors();
    do_issue(2'd1); do_issue(2'd0); do_issue(2'd0);
    send_b(2'd1, 2'd2);
    checks++;
    if ({err_valid, err_id, err_resp} !== 5'b1_01_10) begin
      errors++;
      $display("FAIL err_first got ev=%b id=%0d resp=%0d required 1 1 2", err_valid, err_id, err_resp);
    end
    send_b(2'd0, 2'd3);
    checks++;
    if ({err_valid, err_id, err_resp} !== 5'b1_01_10) begin
      errors++;
      $display("FAIL err_sticky got ev=%b id=%0d resp=%0d required 1 1 2", err_valid, err_id, err_resp);
    end
    err_clear = 1'b1;
    send_b(2'd0, 2'd3);
    err_clear = 1'b0;
    checks++;
    if ({err_valid, err_id, err_resp} !== 5'b1_00_11) begin
      errors++;
      $display("FAIL err_clear_race got ev=%b id=%0d resp=%0d required 1 0 3", err_valid, err_id, err_resp);
    end
    pulse_clear();
    checks++;
    if (err_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got ev=%b required 0", err_valid);
    end
    step();
  endtask

  task automatic test_collision();
    do_issue(2'd0);
    issue_valid = 1'b1; issue_id = 2'd0;
    b_if.bvalid = 1'b1; b_if.bid = 2'd0; b_if.bresp = 2'd0;
    #1;
    checks++;
    if (issue_ready !== 1'b1 || b_if.bready !== 1'b1) begin
      errors++;
      $display("FAIL coll_ready got issue_ready=%b bready=%b required 1 1", issue_ready, b_if.bready);
    end
    @(posedge clock);
    #1;
    issue_valid = 1'b0;
    b_if.bvalid = 1'b0;
    sb_q.push_back({2'd0, 2'd0});
    checks++;
    if (done_valid !== 4'b0001) begin
      errors++;
      $display("FAIL coll_done got dv=%b required 0001", done_valid);
    end
    step();
    checks++;
    if (idle !== 1'b0) begin
      errors++;
      $display("FAIL coll_count got idle=%b required 0", idle);
    end
    send_b(2'd0, 2'd0);
    step(); step();
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL coll_drain got idle=%b required 1", idle);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] jj;
    for (int j = 0; j < 4; j++) do_issue(2'(j));
    for (int j = 0; j < 4; j++) begin
      jj = 2'(j);
      b_if.bvalid = 1'b1; b_if.bid = jj; b_if.bresp = 2'(3 - j);
      #1;
      checks++;
      if (b_if.bready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_bready beat=%0d got=%b required 1", j, b_if.bready);
      end
      @(posedge clock);
      #1;
      cnt_m[jj]--;
      sb_q.push_back({jj, 2'(3 - j)});
    end
    b_if.bvalid = 1'b0;
    step(); step();
    checks++;
    if (sb_q.size() != 0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain got pending=%0d idle=%b required 0 1", sb_q.size(), idle);
    end
    pulse_clear();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reset_midflight();
    test_throttle();
    test_backpressure();
    test_unexpected();
    test_errors();
    test_collision();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got pending=%0d required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
